subtrator_serial: RTL and testbench
===================================

// Module: subtrator_serial
// PURPOSE
//  Bit-serial subtractor: the inverse operation of the ripple-carry adder path.
//  Computes d = a - b over WIDTH cycles using ONE full-adder cell
//  (a + ~b + 1, LSB first). Reports borrow, signed overflow and zero flags.
//  Sits between the operand source and the result consumer; both sides use valid/ready.
// PARAMETERS
//  WIDTH  4  operand/result width in bits; legal range 2..32
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand pair a/b is valid
//  in_ready   out  1      block is idle and accepts operands
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  out_valid  out  1      result outputs are valid and held
//  out_ready  in   1      consumer takes the result
//  d          out  WIDTH  difference a-b, modulo 2^WIDTH
//  borrow     out  1      1 when unsigned a < b (= ~carry_out)
//  ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
//  zero       out  1      1 when d == 0
// BEHAVIOUR
//  Reset: asynchronous on rst_n low.
//   - state=IDLE; counter, shift registers and carry are cleared.
//   - out_valid=0, d=0, borrow=0, ovf=0, zero=0; in_ready=1 (decoded from IDLE).
//   - Reset mid-operation aborts the operation; no partial result is ever presented.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE
//   - in_ready=1.
//   - On in_valid at an edge: load a_sh=a, b_sh=b, carry=1, cnt=0; go to SHIFT.
//  SHIFT (in_ready=0), on each edge:
//   - {c,s} = fa(a_sh[0], ~b_sh[0], carry).
//   - d_sh is shifted right with s entering the MSB; a_sh and b_sh are shifted right.
//   - carry <= c.
//   - When cnt == WIDTH-2, latch the current carry as c_msb_in.
//   - cnt++. On the edge with cnt == WIDTH-1, go to DONE and register the outputs:
//     d=d_sh (final), borrow=~c, ovf=c_msb_in^c, zero=(d==0), out_valid=1.
//  DONE
//   - out_valid=1; outputs stay stable until out_ready=1 at an edge.
//   - Then out_valid<=0 and state goes to IDLE.
//   - A new operand is accepted no earlier than the next edge; there is no same-cycle turnaround.
//  Latency: out_valid rises exactly WIDTH edges after the accepting edge.
//   Throughput is at best one result per WIDTH+2 cycles.
//  in_valid/a/b are ignored outside IDLE. out_ready is ignored outside DONE.
//  d, borrow, ovf and zero hold their last values while in IDLE/SHIFT; they are
//   valid only while out_valid=1.
//  Arithmetic is pure two's-complement modulo 2^WIDTH. No saturation.
// STRUCTURE
//  Package subtrator_pkg:
//   - typedef enum logic [1:0] {IDLE, SHIFT, DONE} estado_t.
//   - localparam CNT_W = $clog2(WIDTH) (minimum 1).
//  Sub-module: instantiate the team full-adder cell somadorcompleto once.
//   - Inputs: a_sh[0], ~b_sh[0], carry. Outputs: s, c.
//  All other logic (FSM, counter, shifters, flags) lives in this module.
// TESTING
//  1. a=4'b1000, b=4'b1010 -> after 4 cycles: d=4'b1110, borrow=1, ovf=0, zero=0.
//  2. a=4'b1010, b=4'b1000 -> d=4'b0010, borrow=0, ovf=0, zero=0.
//  3. a=4'b0101, b=4'b0101 -> d=4'b0000, borrow=0, zero=1.
//  4. a=4'b0111, b=4'b1000 -> d=4'b1111, ovf=1, borrow=1.
//     Also a=4'b1000, b=4'b0001 -> d=4'b0111, ovf=1, borrow=0.
//  5. Backpressure: hold out_ready=0 for 3 cycles after out_valid.
//     -> d and flags stable, in_ready=0.
//     -> A new in_valid during that time is not captured.
//     -> One cycle after out_ready=1, in_ready=1.
//  6. rst_n low for 1 cycle during SHIFT (cnt=2).
//     -> out_valid=0 and in_ready=1 immediately.
//     -> A following op a=3, b=1 yields d=2 with no stale bits.
//  Checks: in_valid held high continuously -> exactly one result per WIDTH+2 cycles.
//  Checks: random a/b with WIDTH=8 compared against a-b reference model.

Source files
------------

// File: rtl/subtrator_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Imported by the top and the full-adder cell.
package subtrator_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} estado_t;

   // Counter width for a given operand width, never below one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return ($clog2(width) > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/somadorcompleto.sv
// Single-bit full-adder cell shared by the serial arithmetic blocks.
module somadorcompleto
   import subtrator_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic c
);

   assign s = a ^ b ^ cin;
   assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial subtractor: d = a - b computed LSB first as a + ~b + 1 through one
// full-adder cell, with borrow, signed-overflow and zero flags; valid/ready on both sides.
module subtrator_serial
   import subtrator_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             borrow,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned     CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

   estado_t          estado;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] d_sh;
   logic             carry;
   logic             c_msb_in;
   logic             s;
   logic             c;
   logic [WIDTH-1:0] d_fin;

   assign in_ready = (estado == IDLE);

   somadorcompleto u_fa (
      .a   (a_sh[0]),
      .b   (~b_sh[0]),
      .cin (carry),
      .s   (s),
      .c   (c)
   );

   // Difference as it will look once the current sum bit is shifted in.
   assign d_fin = {s, d_sh[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado    <= IDLE;
         cnt       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         d_sh      <= '0;
         carry     <= 1'b0;
         c_msb_in  <= 1'b0;
         out_valid <= 1'b0;
         d         <= '0;
         borrow    <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (estado)
            IDLE: begin
               if (in_valid) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  d_sh   <= '0;
                  carry  <= 1'b1;
                  cnt    <= '0;
                  estado <= SHIFT;
               end
            end
            SHIFT: begin
               d_sh  <= d_fin;
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= c;
               cnt   <= cnt + 1'b1;
               // Carry out of bit WIDTH-2 is the carry into the MSB.
               if (cnt == CNT_PEN) begin
                  c_msb_in <= c;
               end
               if (cnt == CNT_LAST) begin
                  estado    <= DONE;
                  d         <= d_fin;
                  borrow    <= ~c;
                  ovf       <= c_msb_in ^ c;
                  zero      <= (d_fin == '0);
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  estado    <= IDLE;
               end
            end
            default: estado <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_subtrator_serial.sv
// Directed and model-checked bench for subtrator_serial at WIDTH=4 and WIDTH=8.
module tb_subtrator_serial;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;

   logic       in_ready4, out_valid4, borrow4, ovf4, zero4;
   logic [3:0] d4;
   logic       in_ready8, out_valid8, borrow8, ovf8, zero8;
   logic [7:0] d8;

   logic       in_ready_m, out_valid_m, borrow_m, ovf_m, zero_m;
   logic [7:0] d_m;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   subtrator_serial #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid & ~sel),
      .in_ready  (in_ready4),
      .a         (a[3:0]),
      .b         (b[3:0]),
      .out_valid (out_valid4),
      .out_ready (out_ready & ~sel),
      .d         (d4),
      .borrow    (borrow4),
      .ovf       (ovf4),
      .zero      (zero4)
   );

   subtrator_serial #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid & sel),
      .in_ready  (in_ready8),
      .a         (a),
      .b         (b),
      .out_valid (out_valid8),
      .out_ready (out_ready & sel),
      .d         (d8),
      .borrow    (borrow8),
      .ovf       (ovf8),
      .zero      (zero8)
   );

   assign in_ready_m  = sel ? in_ready8  : in_ready4;
   assign out_valid_m = sel ? out_valid8 : out_valid4;
   assign borrow_m    = sel ? borrow8    : borrow4;
   assign ovf_m       = sel ? ovf8       : ovf4;
   assign zero_m      = sel ? zero8      : zero4;
   assign d_m         = sel ? d8         : {4'b0, d4};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One operation: accept, count latency, check result; optionally complete the handshake.
   task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic [7:0] ed, input logic eb, input logic eo,
                         input logic ez, input bit hand);
      int w;
      bit early;
      w = sel ? 8 : 4;
      early = 1'b0;
      @(negedge clk);
      check_eq({tag, ".in_ready_idle"}, in_ready_m, 1);
      a = ta;
      b = tb_v;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = ~ta;
      b = ~tb_v;
      for (int k = 0; k < w; k++) begin
         if (out_valid_m || in_ready_m) early = 1'b1;
         @(negedge clk);
      end
      check_eq({tag, ".busy_latency"}, early, 0);
      check_eq({tag, ".out_valid"}, out_valid_m, 1);
      check_eq({tag, ".d"}, d_m, ed);
      check_eq({tag, ".borrow"}, borrow_m, eb);
      check_eq({tag, ".ovf"}, ovf_m, eo);
      check_eq({tag, ".zero"}, zero_m, ez);
      if (hand) begin
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         check_eq({tag, ".ov_drop"}, out_valid_m, 0);
         check_eq({tag, ".in_ready_back"}, in_ready_m, 1);
      end
   endtask

   initial begin
      int rise0, rise1, rise2, nrise;
      logic prev;
      repeat (3) @(negedge clk);
      check_eq("rst.in_ready", in_ready_m, 1);
      check_eq("rst.out_valid", out_valid_m, 0);
      check_eq("rst.flags", {d_m, borrow_m, ovf_m, zero_m}, 0);
      rst_n = 1'b1;

      run_op("v1", 8'h8, 8'hA, 8'hE, 1, 0, 0, 1);
      run_op("v2", 8'hA, 8'h8, 8'h2, 0, 0, 0, 1);
      run_op("v3", 8'h5, 8'h5, 8'h0, 0, 0, 1, 1);
      run_op("v4a", 8'h7, 8'h8, 8'hF, 1, 1, 0, 1);
      run_op("v4b", 8'h8, 8'h1, 8'h7, 0, 1, 0, 1);

      // Backpressure: result held, new operands refused.
      run_op("bp", 8'h9, 8'h2, 8'h7, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         a = 8'h3;
         b = 8'h3;
         @(negedge clk);
         check_eq("bp.hold", {out_valid_m, in_ready_m, d_m, borrow_m, ovf_m, zero_m},
                  {1'b1, 1'b0, 8'h7, 1'b0, 1'b1, 1'b0});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("bp.release", {out_valid_m, in_ready_m}, 2'b01);
      repeat (6) @(negedge clk);
      check_eq("bp.not_captured", {out_valid_m, in_ready_m}, 2'b01);

      // Reset in the middle of SHIFT.
      @(negedge clk);
      a = 8'h5;
      b = 8'h1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("mrst.state", {out_valid_m, in_ready_m}, 2'b01);
      check_eq("mrst.d", d_m, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_rst", 8'h3, 8'h1, 8'h2, 0, 0, 0, 1);

      // Continuous in_valid: one result per WIDTH+2 cycles.
      a = 8'h6;
      b = 8'h2;
      in_valid = 1'b1;
      out_ready = 1'b1;
      rise0 = -1; rise1 = -1; rise2 = -1; nrise = 0;
      prev = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (out_valid_m && !prev) begin
            if (nrise == 0) rise0 = cyc;
            else if (nrise == 1) rise1 = cyc;
            else if (nrise == 2) rise2 = cyc;
            nrise++;
            if (nrise == 1) check_eq("tp.d", d_m, 8'h4);
         end
         prev = out_valid_m;
      end
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      out_ready = 1'b0;
      check_eq("tp.gap1", rise1 - rise0, 6);
      check_eq("tp.gap2", rise2 - rise1, 6);

      // WIDTH=8 against an integer reference model.
      sel = 1'b1;
      for (int i = 0; i < 16; i++) begin
         logic [7:0] ra, rb, ed;
         logic eb, eo, ez;
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (i == 0) begin ra = 8'h80; rb = 8'h01; end
         if (i == 1) begin ra = 8'h33; rb = 8'h33; end
         ed = ra - rb;
         eb = (ra < rb);
         eo = (ra[7] != rb[7]) && (ed[7] != ra[7]);
         ez = (ed == 8'h0);
         run_op($sformatf("w8_%0d", i), ra, rb, ed, eb, eo, ez, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
